// File: rtl/drop_animator_if.sv
// drop_animator_if: drop request from the turn controller and animation/commit results toward board and renderer
interface drop_animator_if #(parameter int RW = 3, CW = 3);
  logic          drop_req;
  logic [CW-1:0] drop_col;
  logic          drop_player;
  logic [RW-1:0] col_height;
  logic          busy;
  logic          anim_valid;
  logic [RW-1:0] anim_row;
  logic [CW-1:0] anim_col;
  logic          anim_player;
  logic          commit;
  logic [RW-1:0] commit_row;
  logic [CW-1:0] commit_col;
  logic          commit_player;
  logic          reject;
  modport master (
    output drop_req, drop_col, drop_player, col_height,
    input  busy, anim_valid, anim_row, anim_col, anim_player,
           commit, commit_row, commit_col, commit_player, reject
  );
  modport slave (
    input  drop_req, drop_col, drop_player, col_height,
    output busy, anim_valid, anim_row, anim_col, anim_player,
           commit, commit_row, commit_col, commit_player, reject
  );
endinterface

// File: rtl/drop_animator.sv
// drop_animator: steps a Connect-4 piece down its column one row per tick, then commits it to the board
module drop_animator #(
  parameter int ROWS = 6,
  parameter int COLS = 7,
  parameter int RW   = 3,
  parameter int CW   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  drop_animator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FALL, COMMIT} state_t;
  localparam logic [RW-1:0] BOTTOM = RW'(ROWS - 1);
  localparam logic [RW-1:0] FULL   = RW'(ROWS);
  // One extra bit so COLS == 2^CW still compares correctly
  localparam logic [CW:0]   NCOL   = (CW + 1)'(COLS);
  state_t        state;
  logic [RW-1:0] target;
  logic          bad;
  assign bad = ({1'b0, bus.drop_col} >= NCOL) || (bus.col_height >= FULL);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      target            <= '0;
      bus.busy          <= 1'b0;
      bus.anim_valid    <= 1'b0;
      bus.anim_row      <= '0;
      bus.anim_col      <= '0;
      bus.anim_player   <= 1'b0;
      bus.commit        <= 1'b0;
      bus.commit_row    <= '0;
      bus.commit_col    <= '0;
      bus.commit_player <= 1'b0;
      bus.reject        <= 1'b0;
    end else begin
      bus.reject        <= 1'b0;
      bus.commit        <= 1'b0;
      bus.commit_row    <= '0;
      bus.commit_col    <= '0;
      bus.commit_player <= 1'b0;
      case (state)
        IDLE: if (bus.drop_req) begin
          if (bad) bus.reject <= 1'b1;
          else begin
            state           <= FALL;
            target          <= BOTTOM - bus.col_height;
            bus.anim_col    <= bus.drop_col;
            bus.anim_player <= bus.drop_player;
            bus.anim_row    <= '0;
            bus.busy        <= 1'b1;
            bus.anim_valid  <= 1'b1;
          end
        end
        FALL: if (tick) begin
          if (bus.anim_row == target) begin
            state             <= COMMIT;
            bus.anim_valid    <= 1'b0;
            bus.commit        <= 1'b1;
            bus.commit_row    <= target;
            bus.commit_col    <= bus.anim_col;
            bus.commit_player <= bus.anim_player;
          end else bus.anim_row <= bus.anim_row + 1'b1;
        end
        COMMIT: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_drop_animator.sv
// tb_drop_animator: directed scenario tasks with hand-computed expectations for drop_animator
module tb_drop_animator;
  logic clk = 1'b0;
  logic rst_n;
  logic tick;
  int   pass_cnt = 0;
  int   tot = 0;
  drop_animator_if #(.RW(3), .CW(3)) bus ();
  drop_animator #(.ROWS(6), .COLS(7), .RW(3), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  // Advance to just after the next rising edge; all sampling and driving happens here
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic request(input logic [2:0] c, input logic [2:0] h, input logic p);
    bus.drop_req = 1'b1; bus.drop_col = c; bus.col_height = h; bus.drop_player = p;
    cyc();
    bus.drop_req = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; tick = 1'b0;
    bus.drop_req = 1'b0; bus.drop_col = '0; bus.col_height = '0; bus.drop_player = 1'b0;
    cyc(); cyc();
    tot++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", bus.busy); else pass_cnt++;
    tot++; if (bus.anim_valid !== 1'b0) $display("FAIL reset_anim_valid got %0b want 0", bus.anim_valid); else pass_cnt++;
    tot++; if (bus.commit !== 1'b0) $display("FAIL reset_commit got %0b want 0", bus.commit); else pass_cnt++;
    tot++; if (bus.reject !== 1'b0) $display("FAIL reset_reject got %0b want 0", bus.reject); else pass_cnt++;
    tot++; if (bus.anim_row !== 3'd0) $display("FAIL reset_anim_row got %0d want 0", bus.anim_row); else pass_cnt++;
    rst_n = 1'b1;
    cyc();
  endtask
  task automatic test_empty_column();
    request(3'd3, 3'd0, 1'b1);
    tot++; if (bus.busy !== 1'b1) $display("FAIL empty_busy got %0b want 1", bus.busy); else pass_cnt++;
    tot++; if (bus.anim_valid !== 1'b1) $display("FAIL empty_anim_valid got %0b want 1", bus.anim_valid); else pass_cnt++;
    tot++; if (bus.anim_row !== 3'd0) $display("FAIL empty_row0 got %0d want 0", bus.anim_row); else pass_cnt++;
    for (int k = 1; k <= 6; k++) begin
      repeat (9) cyc();
      tot++; if (bus.anim_row !== 3'(k - 1)) $display("FAIL empty_hold k=%0d got %0d want %0d", k, bus.anim_row, k - 1); else pass_cnt++;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      if (k <= 5) begin
        tot++; if (bus.anim_row !== 3'(k)) $display("FAIL empty_step k=%0d got %0d want %0d", k, bus.anim_row, k); else pass_cnt++;
        tot++; if (bus.commit !== 1'b0) $display("FAIL empty_early_commit k=%0d got %0b want 0", k, bus.commit); else pass_cnt++;
      end
    end
    tot++; if (bus.commit !== 1'b1) $display("FAIL empty_commit got %0b want 1", bus.commit); else pass_cnt++;
    tot++; if (bus.commit_row !== 3'd5) $display("FAIL empty_commit_row got %0d want 5", bus.commit_row); else pass_cnt++;
    tot++; if (bus.commit_col !== 3'd3) $display("FAIL empty_commit_col got %0d want 3", bus.commit_col); else pass_cnt++;
    tot++; if (bus.commit_player !== 1'b1) $display("FAIL empty_commit_player got %0b want 1", bus.commit_player); else pass_cnt++;
    tot++; if (bus.anim_valid !== 1'b0) $display("FAIL empty_commit_anim_valid got %0b want 0", bus.anim_valid); else pass_cnt++;
    tot++; if (bus.busy !== 1'b1) $display("FAIL empty_commit_busy got %0b want 1", bus.busy); else pass_cnt++;
    cyc();
    tot++; if (bus.commit !== 1'b0) $display("FAIL empty_commit_pulse got %0b want 0", bus.commit); else pass_cnt++;
    tot++; if (bus.commit_row !== 3'd0) $display("FAIL empty_commit_row_clear got %0d want 0", bus.commit_row); else pass_cnt++;
    tot++; if (bus.busy !== 1'b0) $display("FAIL empty_busy_drop got %0b want 0", bus.busy); else pass_cnt++;
  endtask
  task automatic test_nearly_full();
    request(3'd2, 3'd5, 1'b0);
    tot++; if (bus.anim_row !== 3'd0) $display("FAIL near_row got %0d want 0", bus.anim_row); else pass_cnt++;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    tot++; if (bus.commit !== 1'b1) $display("FAIL near_commit got %0b want 1", bus.commit); else pass_cnt++;
    tot++; if (bus.commit_row !== 3'd0) $display("FAIL near_commit_row got %0d want 0", bus.commit_row); else pass_cnt++;
    tot++; if (bus.commit_col !== 3'd2) $display("FAIL near_commit_col got %0d want 2", bus.commit_col); else pass_cnt++;
    tot++; if (bus.anim_row !== 3'd0) $display("FAIL near_row_stay got %0d want 0", bus.anim_row); else pass_cnt++;
    cyc();
  endtask
  task automatic test_reject();
    request(3'd4, 3'd6, 1'b1);
    tot++; if (bus.reject !== 1'b1) $display("FAIL full_reject got %0b want 1", bus.reject); else pass_cnt++;
    tot++; if (bus.busy !== 1'b0) $display("FAIL full_busy got %0b want 0", bus.busy); else pass_cnt++;
    cyc();
    tot++; if (bus.reject !== 1'b0) $display("FAIL full_reject_pulse got %0b want 0", bus.reject); else pass_cnt++;
    request(3'd7, 3'd0, 1'b0);
    tot++; if (bus.reject !== 1'b1) $display("FAIL badcol_reject got %0b want 1", bus.reject); else pass_cnt++;
    tot++; if (bus.busy !== 1'b0) $display("FAIL badcol_busy got %0b want 0", bus.busy); else pass_cnt++;
    tick = 1'b1;
    repeat (3) begin
      cyc();
      tot++; if (bus.commit !== 1'b0 || bus.busy !== 1'b0) $display("FAIL badcol_no_commit got commit=%0b busy=%0b want 0 0", bus.commit, bus.busy); else pass_cnt++;
    end
    tick = 1'b0;
  endtask
  task automatic test_busy_lockout();
    request(3'd1, 3'd3, 1'b1);
    tick = 1'b1; cyc(); tick = 1'b0;
    tot++; if (bus.anim_row !== 3'd1) $display("FAIL lock_row1 got %0d want 1", bus.anim_row); else pass_cnt++;
    bus.drop_req = 1'b1; bus.drop_col = 3'd0; bus.col_height = 3'd0; bus.drop_player = 1'b0;
    cyc();
    bus.drop_req = 1'b0;
    tot++; if (bus.reject !== 1'b0) $display("FAIL lock_no_reject got %0b want 0", bus.reject); else pass_cnt++;
    tot++; if (bus.anim_col !== 3'd1) $display("FAIL lock_anim_col got %0d want 1", bus.anim_col); else pass_cnt++;
    tick = 1'b1; cyc(); cyc(); tick = 1'b0;
    tot++; if (bus.commit !== 1'b1) $display("FAIL lock_commit got %0b want 1", bus.commit); else pass_cnt++;
    tot++; if (bus.commit_col !== 3'd1) $display("FAIL lock_commit_col got %0d want 1", bus.commit_col); else pass_cnt++;
    tot++; if (bus.commit_row !== 3'd2) $display("FAIL lock_commit_row got %0d want 2", bus.commit_row); else pass_cnt++;
    bus.drop_req = 1'b1; bus.drop_col = 3'd5; bus.col_height = 3'd5; bus.drop_player = 1'b0;
    cyc();
    tot++; if (bus.busy !== 1'b0) $display("FAIL lock_commit_req_ignored got busy=%0b want 0", bus.busy); else pass_cnt++;
    cyc();
    bus.drop_req = 1'b0;
    tot++; if (bus.busy !== 1'b1) $display("FAIL lock_first_idle_accept got busy=%0b want 1", bus.busy); else pass_cnt++;
    tot++; if (bus.anim_col !== 3'd5) $display("FAIL lock_new_col got %0d want 5", bus.anim_col); else pass_cnt++;
    tick = 1'b1; cyc(); tick = 1'b0;
    tot++; if (bus.commit !== 1'b1 || bus.commit_col !== 3'd5) $display("FAIL lock_new_commit got commit=%0b col=%0d want 1 5", bus.commit, bus.commit_col); else pass_cnt++;
    cyc();
  endtask
  task automatic test_tick_coincidence();
    tick = 1'b1;
    request(3'd0, 3'd0, 1'b0);
    tot++; if (bus.anim_row !== 3'd0) $display("FAIL coin_row0 got %0d want 0", bus.anim_row); else pass_cnt++;
    tot++; if (bus.anim_valid !== 1'b1) $display("FAIL coin_valid got %0b want 1", bus.anim_valid); else pass_cnt++;
    cyc();
    tick = 1'b0;
    tot++; if (bus.anim_row !== 3'd1) $display("FAIL coin_row1 got %0d want 1", bus.anim_row); else pass_cnt++;
  endtask
  task automatic test_reset_mid_fall();
    tick = 1'b1; cyc(); cyc(); tick = 1'b0;
    tot++; if (bus.anim_row !== 3'd3) $display("FAIL rst_pre_row got %0d want 3", bus.anim_row); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    tot++; if (bus.anim_row !== 3'd0) $display("FAIL rst_async_row got %0d want 0", bus.anim_row); else pass_cnt++;
    tot++; if (bus.busy !== 1'b0 || bus.anim_valid !== 1'b0) $display("FAIL rst_async_busy got busy=%0b valid=%0b want 0 0", bus.busy, bus.anim_valid); else pass_cnt++;
    tot++; if (bus.anim_col !== 3'd0) $display("FAIL rst_async_col got %0d want 0", bus.anim_col); else pass_cnt++;
    tick = 1'b1;
    cyc(); cyc();
    rst_n = 1'b1;
    repeat (6) begin
      cyc();
      tot++; if (bus.commit !== 1'b0 || bus.busy !== 1'b0) $display("FAIL rst_no_commit got commit=%0b busy=%0b want 0 0", bus.commit, bus.busy); else pass_cnt++;
    end
    tick = 1'b0;
    request(3'd6, 3'd4, 1'b1);
    tick = 1'b1; cyc();
    tot++; if (bus.anim_row !== 3'd1) $display("FAIL rst_after_row got %0d want 1", bus.anim_row); else pass_cnt++;
    cyc(); tick = 1'b0;
    tot++; if (bus.commit !== 1'b1 || bus.commit_row !== 3'd1 || bus.commit_col !== 3'd6 || bus.commit_player !== 1'b1)
      $display("FAIL rst_after_commit got c=%0b r=%0d col=%0d p=%0b want 1 1 6 1", bus.commit, bus.commit_row, bus.commit_col, bus.commit_player);
    else pass_cnt++;
    cyc();
  endtask
  initial begin
    test_reset();
    test_empty_column();
    test_nearly_full();
    test_reject();
    test_busy_lockout();
    test_tick_coincidence();
    test_reset_mid_fall();
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule

// File: doc/drop_animator.md
Name: drop_animator

Overview:
- Consumes the single-cycle rate pulse from the game's clock-enable divider and animates a Connect-4 piece falling down the selected column, one row per pulse.
- When the piece reaches its landing row, issues a one-cycle commit to the board register. Full or invalid columns are rejected.
- Sits between the column-select/turn controller (upstream) and the board state plus VGA renderer (downstream).

Parameters:
- ROWS, 6, board rows; row 0 is the top row and ROWS-1 the bottom row.
- COLS, 7, board columns, numbered 0..COLS-1.
- RW, 3, row index width; must satisfy 2^RW >= ROWS+1.
- CW, 3, column index width; must satisfy 2^CW >= COLS.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  single-cycle enable pulse from the rate divider; advances the fall by one row.
- drop_req  in  1  request to drop a piece; sampled only in IDLE.
- drop_col  in  CW  requested column; valid with drop_req.
- drop_player  in  1  player owning the piece; valid with drop_req.
- col_height  in  RW  current piece count in drop_col (0..ROWS); supplied combinationally by the board, valid with drop_req.
- busy  out  1  high in FALL and COMMIT.
- anim_valid  out  1  high in FALL; renderer draws the falling piece.
- anim_row  out  RW  current row of the falling piece.
- anim_col  out  CW  latched column.
- anim_player  out  1  latched player.
- commit  out  1  one-cycle pulse: write piece to board.
- commit_row  out  RW  landing row; valid with commit.
- commit_col  out  CW  landing column; valid with commit.
- commit_player  out  1  valid with commit.
- reject  out  1  one-cycle pulse: request refused.

Behaviour:
- States: IDLE, FALL, COMMIT. All outputs are registered.
- Reset (async, rst_n low): state IDLE. All outputs and latched fields are 0. Any in-flight drop is discarded and no commit is issued.
- IDLE, drop_req=1 at cycle N:
  - Reject case: drop_col >= COLS or col_height >= ROWS. Set reject=1 in cycle N+1 only; stay in IDLE; busy stays 0.
  - Accept case: latch col, player, and target = ROWS-1-col_height (RW-bit unsigned). In cycle N+1: state FALL, busy=1, anim_valid=1, anim_row=0.
- FALL, on each cycle with tick=1:
  - If anim_row == target: go to COMMIT on the next cycle. anim_row holds its value.
  - Otherwise: anim_row increments by 1.
  - Cycles with tick=0 hold all state.
- COMMIT (exactly one cycle):
  - commit=1, with commit_row=target, commit_col=latched col, commit_player=latched player.
  - anim_valid=0, busy=1.
  - Next state is IDLE.
- commit_row, commit_col and commit_player are 0 whenever commit=0.
- Latency: for a landing row T, commit asserts 1 cycle after the (T+1)-th tick seen in FALL. The first FALL cycle counts if tick=1 in that cycle.
- Simultaneous events:
  - tick in the same cycle as an accepted drop_req (IDLE) is ignored.
  - drop_req while busy is ignored: no reject, no latch.
  - drop_req in the COMMIT cycle is ignored. A request is accepted no earlier than the first IDLE cycle.
- The latched col, player and target are frozen from acceptance until return to IDLE. Input changes during FALL have no effect.
- The anim_row increment never exceeds target, so no wrap-around is possible.

Test Plan:
- Empty column: drop_req, drop_col=3, col_height=0, player=1; ticks every 10 cycles -> anim_row steps 0,1,2,3,4,5 on ticks 1-5. The 6th tick is followed one cycle later by commit=1, commit_row=5, commit_col=3, commit_player=1. busy drops the cycle after commit.
- Nearly full column: col_height=5 -> target 0. The first tick in FALL gives commit the next cycle with commit_row=0, and anim_row never leaves 0.
- Full and invalid columns: col_height=6 -> reject=1 for one cycle, busy=0. Separately, drop_col=7, col_height=0 -> reject=1, no commit.
- Busy lockout: during FALL, assert drop_req with drop_col=0 -> no reject. The final commit still reports the original column. A new request in the first IDLE cycle is accepted.
- Tick coincidence: tick=1 in the same cycle as drop_req (col_height=0) -> anim_row=0 in cycle N+1, i.e. the tick is not counted. tick=1 in cycle N+1 -> anim_row=1 in cycle N+2.
- Reset mid-fall: rst_n=0 at anim_row=3 -> all outputs 0 immediately (asynchronously). No commit after release. A subsequent drop behaves normally.
